// File: rtl/regbus_pkg.sv
// Shared constants for the register-bank arbiter: state encoding, default
// bus widths and the stall-counter width.
package regbus_pkg;

  localparam int ADRW_DEF    = 2;
  localparam int DATW_DEF    = 3;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_A_HOLD  = 2'd1,
    ST_B_RDCAP = 2'd2
  } st_e;

endpackage

// File: rtl/regbus_arbiter_if.sv
// Signal bundle between the bus slave (port A), the internal master (port B)
// and the register bank. The arbiter uses the slave modport.
interface regbus_arbiter_if
  import regbus_pkg::*;
#(
  parameter int ADRW = ADRW_DEF,
  parameter int DATW = DATW_DEF
) ();

  logic            a_do_read;
  logic            a_do_write;
  logic [ADRW-1:0] a_adr;
  logic [DATW-1:0] a_wdata;
  logic [DATW-1:0] a_rdata;

  logic            b_req;
  logic            b_we;
  logic [ADRW-1:0] b_adr;
  logic [DATW-1:0] b_wdata;
  logic            b_ack;
  logic [DATW-1:0] b_rdata;

  logic            reg_we;
  logic            reg_re;
  logic [ADRW-1:0] reg_adr;
  logic [DATW-1:0] reg_wdata;
  logic [DATW-1:0] reg_rdata;

  modport slave (
    input  a_do_read, a_do_write, a_adr, a_wdata,
    input  b_req, b_we, b_adr, b_wdata,
    input  reg_rdata,
    output a_rdata, b_ack, b_rdata,
    output reg_we, reg_re, reg_adr, reg_wdata
  );

  modport master (
    output a_do_read, a_do_write, a_adr, a_wdata,
    output b_req, b_we, b_adr, b_wdata,
    output reg_rdata,
    input  a_rdata, b_ack, b_rdata,
    input  reg_we, reg_re, reg_adr, reg_wdata
  );

endinterface

// File: rtl/regbus_stall_counter.sv
// Saturating event counter used to measure how long port B is held off.
module regbus_stall_counter
  import regbus_pkg::*;
#(
  parameter int W = STALL_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Two-port arbiter for the register bank: A (bus slave strobes) always wins with
// zero latency, B (req/ack master) fills idle cycles. Define REGBUS_ARB_STATS_EN
// to add the b_stall_cnt output.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int ADRW = ADRW_DEF,
  parameter int DATW = DATW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  regbus_arbiter_if.slave        bus
`ifdef REGBUS_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] b_stall_cnt
`endif
);

  st_e             st, st_nxt;
  logic            b_ack_q, b_ack_nxt, b_cap;
  logic [DATW-1:0] b_rdata_q;
  logic            reg_we_c, reg_re_c;
  logic [ADRW-1:0] reg_adr_c;
  logic [DATW-1:0] reg_wdata_c;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      b_ack_q   <= 1'b0;
      b_rdata_q <= '0;
    end else begin
      st      <= st_nxt;
      b_ack_q <= b_ack_nxt;
      if (b_cap) b_rdata_q <= bus.reg_rdata;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    st_nxt      = ST_IDLE;
    b_ack_nxt   = 1'b0;
    b_cap       = 1'b0;
    reg_we_c    = 1'b0;
    reg_re_c    = 1'b0;
    reg_adr_c   = bus.a_adr;
    reg_wdata_c = bus.a_wdata;

    // An A strobe preempts whatever B was doing; an aborted B read restarts
    // from IDLE because b_req is still held.
    if (bus.a_do_write) begin
      reg_we_c = 1'b1;
    end else if (bus.a_do_read) begin
      reg_re_c = 1'b1;
      st_nxt   = ST_A_HOLD;
    end else begin
      case (st)
        ST_IDLE: begin
          if (bus.b_req) begin
            reg_adr_c = bus.b_adr;
            if (bus.b_we) begin
              reg_we_c    = 1'b1;
              reg_wdata_c = bus.b_wdata;
              b_ack_nxt   = 1'b1;
            end else begin
              reg_re_c = 1'b1;
              st_nxt   = ST_B_RDCAP;
            end
          end
        end
        ST_A_HOLD: begin
          // keep a_adr on the bank so the bus slave latches settled data
        end
        ST_B_RDCAP: begin
          reg_adr_c = bus.b_adr;
          b_cap     = 1'b1;
          b_ack_nxt = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.reg_we    = reg_we_c & ~rst;
  assign bus.reg_re    = reg_re_c & ~rst;
  assign bus.reg_adr   = reg_adr_c;
  assign bus.reg_wdata = reg_wdata_c;
  assign bus.a_rdata   = bus.reg_rdata;
  assign bus.b_ack     = b_ack_q;
  assign bus.b_rdata   = b_rdata_q;

`ifdef REGBUS_ARB_STATS_EN
  logic b_blocked;

  // An abort in B_RDCAP is always caused by an A strobe, so it is covered here.
  assign b_blocked = bus.b_req & ~b_ack_q &
                     (bus.a_do_read | bus.a_do_write | (st == ST_A_HOLD));

  regbus_stall_counter #(.W(STALL_CNT_W)) u_stall_counter (
    .clk (clk),
    .rst (rst),
    .inc (b_blocked),
    .cnt (b_stall_cnt)
  );
`endif

endmodule
